// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the request legality check used at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } lsu_state_e;

  // Returns 1 when the op must be dropped with a trap: misaligned halfword or
  // word, unsigned store variants, or an unused funct3 encoding.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] func3,
                                         input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (func3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load byte/half extraction with sign/zero
// extension, and store lane merge into the word read back from BRAM.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  input  logic [15:0]     wdata_lo,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merge_data
);

  logic [XLEN-1:0] shifted;

  // Legal halfword offsets are 0 or 2, so one byte-granular shift serves both sizes.
  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    load_data = shifted;
    case (func3)
      F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
    localparam int LANE = gi;
    assign merge_data[LANE*8 +: 8] =
        (func3 == F3_B && off == 2'(LANE))       ? wdata_lo[7:0] :
        (func3 == F3_H && off[1] == 1'(LANE/2))  ? wdata_lo[(LANE%2)*8 +: 8] :
                                                   rdata[LANE*8 +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequences one CPU load/store at a time onto a word-wide single-port BRAM,
// with read-modify-write for sub-word stores and a pipeline stall meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_is_store,
  input  logic [2:0]       req_func3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             stall,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_rdata,
  output logic             trap_misalign,
  output logic [IDX_W-1:0] mem_idx,
  output logic             mem_re,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_wdata
);

  lsu_state_e      state_reg;
  logic            is_store_reg;
  logic [2:0]      func3_reg;
  logic [1:0]      off_reg;
  logic [15:0]     wdata_lo_reg;
  logic            req_illegal;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merge_data;
  logic            unused_addr_hi;

  // Address bits above the BRAM index simply wrap.
  assign unused_addr_hi = ^req_addr[XLEN-1:IDX_W+2];

  assign req_illegal = is_misaligned(req_is_store, req_func3, req_addr[1:0]);

  assign stall = (state_reg == ST_IDLE && req_valid && !req_illegal) ||
                 (state_reg == ST_RD) || (state_reg == ST_CAP) || (state_reg == ST_WR);

  lsu_align #(.XLEN(XLEN)) u_align (
    .func3      (func3_reg),
    .off        (off_reg),
    .rdata      (mem_rdata),
    .wdata_lo   (wdata_lo_reg),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      is_store_reg  <= 1'b0;
      func3_reg     <= 3'b000;
      off_reg       <= 2'b00;
      wdata_lo_reg  <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      trap_misalign <= 1'b0;
      mem_idx       <= '0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      resp_valid    <= 1'b0;
      trap_misalign <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_illegal) begin
              trap_misalign <= 1'b1;
            end else begin
              is_store_reg <= req_is_store;
              func3_reg    <= req_func3;
              off_reg      <= req_addr[1:0];
              wdata_lo_reg <= req_wdata[15:0];
              mem_idx      <= req_addr[IDX_W+1:2];
              mem_wdata    <= req_wdata;
              // Full-word stores skip the read; everything else needs the old word.
              if (req_is_store && req_func3 == F3_W) begin
                mem_we    <= 1'b1;
                state_reg <= ST_WR;
              end else begin
                mem_re    <= 1'b1;
                state_reg <= ST_RD;
              end
            end
          end
        end
        ST_RD: state_reg <= ST_CAP;
        ST_CAP: begin
          if (is_store_reg) begin
            mem_wdata <= merge_data;
            mem_we    <= 1'b1;
            state_reg <= ST_WR;
          end else begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state_reg  <= ST_DONE;
          end
        end
        ST_WR: begin
          resp_valid <= 1'b1;
          state_reg  <= ST_DONE;
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 1-cycle-read BRAM.
module tb_load_store_unit;

  localparam int IDX_W = 10;
  localparam int XLEN  = 32;
  localparam int NCYC  = 8;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_is_store = 1'b0;
  logic [2:0]       req_func3 = 3'b000;
  logic [XLEN-1:0]  req_addr = '0;
  logic [XLEN-1:0]  req_wdata = '0;
  logic             stall;
  logic             resp_valid;
  logic [XLEN-1:0]  resp_rdata;
  logic             trap_misalign;
  logic [IDX_W-1:0] mem_idx;
  logic             mem_re;
  logic [XLEN-1:0]  mem_rdata;
  logic             mem_we;
  logic [XLEN-1:0]  mem_wdata;

  int vectors = 0;
  int miscompares = 0;

  logic [XLEN-1:0] mem [0:(1<<IDX_W)-1];

  logic             o_stall [NCYC];
  logic             o_re    [NCYC];
  logic             o_we    [NCYC];
  logic             o_rv    [NCYC];
  logic             o_trap  [NCYC];
  logic [XLEN-1:0]  o_rdata [NCYC];
  logic [XLEN-1:0]  o_wdata [NCYC];
  logic [IDX_W-1:0] o_idx   [NCYC];

  always #5 clk = ~clk;

  load_store_unit #(.IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_is_store  (req_is_store),
    .req_func3     (req_func3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .trap_misalign (trap_misalign),
    .mem_idx       (mem_idx),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_idx];
  end

  // Drives one request at a negedge (cycle 0) and records outputs for NCYC cycles.
  // req_valid is held while stall is high, as upstream would.
  task automatic run_op(input logic st, input logic [2:0] f3,
                        input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wd);
    @(negedge clk);
    req_is_store = st;
    req_func3    = f3;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      o_stall[k] = stall;
      o_re[k]    = mem_re;
      o_we[k]    = mem_we;
      o_rv[k]    = resp_valid;
      o_trap[k]  = trap_misalign;
      o_rdata[k] = resp_rdata;
      o_wdata[k] = mem_wdata;
      o_idx[k]   = mem_idx;
      if (k > 0 && !stall) req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({stall, resp_valid, trap_misalign, mem_re, mem_we} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 00000", {stall, resp_valid, trap_misalign, mem_re, mem_we});
    end
    vectors++;
    if (resp_rdata !== 32'h0 || mem_idx !== 10'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data got rdata=%h idx=%h wdata=%h want all 0", resp_rdata, mem_idx, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({stall, resp_valid, trap_misalign, mem_re, mem_we} !== 5'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle got %b want 00000", {stall, resp_valid, trap_misalign, mem_re, mem_we});
    end
    $display("reset: checked");
  endtask

  task automatic test_lw();
    mem[4] = 32'hDEADBEEF;
    run_op(1'b0, LW, 32'h10, 32'h0);
    vectors++;
    if ({o_stall[0], o_stall[1], o_stall[2], o_stall[3]} !== 4'b1110) begin
      miscompares++;
      $display("FAIL lw_stall got %b want 1110", {o_stall[0], o_stall[1], o_stall[2], o_stall[3]});
    end
    vectors++;
    if ({o_re[0], o_re[1], o_re[2], o_re[3]} !== 4'b0100 || o_idx[1] !== 10'd4) begin
      miscompares++;
      $display("FAIL lw_mem_re got re=%b idx=%0d want 0100 idx=4", {o_re[0], o_re[1], o_re[2], o_re[3]}, o_idx[1]);
    end
    vectors++;
    if ({o_rv[2], o_rv[3], o_rv[4]} !== 3'b010 || o_rdata[3] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lw_resp got rv=%b data=%h want 010 deadbeef", {o_rv[2], o_rv[3], o_rv[4]}, o_rdata[3]);
    end
    vectors++;
    if (o_rdata[6] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lw_hold got %h want deadbeef", o_rdata[6]);
    end
    $display("LW 0x10: rdata=%h", o_rdata[3]);
  endtask

  task automatic test_subword_loads();
    logic [2:0]      f3_t   [5] = '{LB, LBU, LH, LHU, LH};
    logic [XLEN-1:0] addr_t [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [XLEN-1:0] exp_t  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000011};
    mem[4] = 32'h80FF0011;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, f3_t[i], addr_t[i], 32'h0);
      vectors++;
      if (o_rv[3] !== 1'b1 || o_rdata[3] !== exp_t[i]) begin
        miscompares++;
        $display("FAIL load_f3_%b_addr_%h got rv=%b data=%h want 1 %h", f3_t[i], addr_t[i], o_rv[3], o_rdata[3], exp_t[i]);
      end
      $display("load f3=%b addr=%h: rdata=%h", f3_t[i], addr_t[i], o_rdata[3]);
    end
  endtask

  task automatic test_sb();
    mem[8] = 32'h11223344;
    run_op(1'b1, LB, 32'h21, 32'h123456AB);
    vectors++;
    if ({o_re[0], o_re[1], o_re[2], o_re[3], o_re[4], o_re[5]} !== 6'b010000) begin
      miscompares++;
      $display("FAIL sb_reads got %b want 010000", {o_re[0], o_re[1], o_re[2], o_re[3], o_re[4], o_re[5]});
    end
    vectors++;
    if ({o_we[0], o_we[1], o_we[2], o_we[3], o_we[4], o_we[5]} !== 6'b000100 ||
        o_wdata[3] !== 32'h1122AB44 || o_idx[3] !== 10'd8) begin
      miscompares++;
      $display("FAIL sb_write got we=%b data=%h idx=%0d want 000100 1122ab44 8",
               {o_we[0], o_we[1], o_we[2], o_we[3], o_we[4], o_we[5]}, o_wdata[3], o_idx[3]);
    end
    vectors++;
    if ({o_rv[3], o_rv[4], o_rv[5]} !== 3'b010 || {o_stall[3], o_stall[4]} !== 2'b10) begin
      miscompares++;
      $display("FAIL sb_resp got rv=%b stall=%b want 010 10", {o_rv[3], o_rv[4], o_rv[5]}, {o_stall[3], o_stall[4]});
    end
    vectors++;
    if (mem[8] !== 32'h1122AB44) begin
      miscompares++;
      $display("FAIL sb_mem got %h want 1122ab44", mem[8]);
    end
    $display("SB 0x21: mem[8]=%h", mem[8]);
  endtask

  task automatic test_sh_sw();
    mem[1] = 32'h0;
    run_op(1'b1, LH, 32'h06, 32'h0000BEEF);
    vectors++;
    if (o_we[3] !== 1'b1 || o_wdata[3] !== 32'hBEEF0000 || o_rv[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL sh_write got we=%b data=%h rv=%b want 1 beef0000 1", o_we[3], o_wdata[3], o_rv[4]);
    end
    $display("SH 0x06: mem_wdata=%h", o_wdata[3]);
    mem[2] = 32'h55555555;
    run_op(1'b1, LW, 32'h08, 32'hCAFEF00D);
    vectors++;
    if ({o_we[0], o_we[1], o_we[2]} !== 3'b010 || o_wdata[1] !== 32'hCAFEF00D || o_idx[1] !== 10'd2) begin
      miscompares++;
      $display("FAIL sw_write got we=%b data=%h idx=%0d want 010 cafef00d 2", {o_we[0], o_we[1], o_we[2]}, o_wdata[1], o_idx[1]);
    end
    vectors++;
    if ({o_re[0], o_re[1], o_re[2], o_re[3]} !== 4'b0 || {o_rv[1], o_rv[2], o_rv[3]} !== 3'b010 ||
        {o_stall[0], o_stall[1], o_stall[2]} !== 3'b110) begin
      miscompares++;
      $display("FAIL sw_timing got re=%b rv=%b stall=%b want 0000 010 110", {o_re[0], o_re[1], o_re[2], o_re[3]},
               {o_rv[1], o_rv[2], o_rv[3]}, {o_stall[0], o_stall[1], o_stall[2]});
    end
    vectors++;
    if (mem[2] !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL sw_mem got %h want cafef00d", mem[2]);
    end
    $display("SW 0x08: mem[2]=%h", mem[2]);
  endtask

  task automatic test_wrap();
    mem[4] = 32'h0BADF00D;
    run_op(1'b0, LW, 32'h0000_1010, 32'h0);
    vectors++;
    if (o_idx[1] !== 10'd4 || o_rv[3] !== 1'b1 || o_rdata[3] !== 32'h0BADF00D || o_trap[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap got idx=%0d rv=%b data=%h trap=%b want 4 1 0badf00d 0", o_idx[1], o_rv[3], o_rdata[3], o_trap[1]);
    end
    $display("LW 0x1010: idx=%0d rdata=%h", o_idx[1], o_rdata[3]);
  endtask

  task automatic test_trap();
    logic            st_t   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]      f3_t   [4] = '{LW, LH, 3'b011, LBU};
    logic [XLEN-1:0] addr_t [4] = '{32'h02, 32'h03, 32'h10, 32'h10};
    logic            acc;
    for (int i = 0; i < 4; i++) begin
      run_op(st_t[i], f3_t[i], addr_t[i], 32'hFFFF_FFFF);
      vectors++;
      if ({o_trap[0], o_trap[1], o_trap[2]} !== 3'b010 || o_stall[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL trap_%0d got trap=%b stall=%b want 010 0", i, {o_trap[0], o_trap[1], o_trap[2]}, o_stall[0]);
      end
      acc = 1'b0;
      for (int k = 0; k < NCYC; k++) acc = acc | o_re[k] | o_we[k] | o_rv[k] | o_stall[k];
      vectors++;
      if (acc !== 1'b0) begin
        miscompares++;
        $display("FAIL trap_noaccess_%0d got activity=%b want 0", i, acc);
      end
      $display("trap case %0d: st=%b f3=%b addr=%h trap=%b", i, st_t[i], f3_t[i], addr_t[i], o_trap[1]);
    end
  endtask

  task automatic test_reset_mid_op();
    logic acc;
    mem[8] = 32'h11223344;
    @(negedge clk);
    req_is_store = 1'b1;
    req_func3    = LB;
    req_addr     = 32'h21;
    req_wdata    = 32'h000000AB;
    req_valid    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    vectors++;
    if ({stall, mem_we, resp_valid, mem_re} !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_mid got stall/we/rv/re=%b want 0000", {stall, mem_we, resp_valid, mem_re});
    end
    @(negedge clk);
    rst_n = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      acc = acc | mem_we | resp_valid | stall;
      @(negedge clk);
    end
    vectors++;
    if (acc !== 1'b0 || mem[8] !== 32'h11223344) begin
      miscompares++;
      $display("FAIL rst_abandon got activity=%b mem=%h want 0 11223344", acc, mem[8]);
    end
    run_op(1'b0, LW, 32'h20, 32'h0);
    vectors++;
    if (o_rv[3] !== 1'b1 || o_rdata[3] !== 32'h11223344) begin
      miscompares++;
      $display("FAIL rst_recover got rv=%b data=%h want 1 11223344", o_rv[3], o_rdata[3]);
    end
    $display("reset mid-SB: mem[8]=%h, next LW=%h", mem[8], o_rdata[3]);
  endtask

  initial begin
    for (int i = 0; i < (1 << IDX_W); i++) mem[i] = '0;
    test_reset();
    test_lw();
    test_subword_loads();
    test_sb();
    test_sh_sw();
    test_wrap();
    test_trap();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
